trigger_seq: RTL and testbench
==============================

TRIGGER_SEQ -- requirements
Module: trigger_seq

Interface
REQ-001 Parameter LANES, default 8: samples per clock, lane 0 = oldest.
REQ-002 Parameter CHANNELS, default 32: probe channels per sample.
REQ-003 Parameter STAGES, default 4: maximum trigger sequence stages.
REQ-004 Parameter CNT_W, default 16: occurrence-counter width.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 arm  in  1  pulse: start or restart the sequence.
REQ-008 disarm  in  1  pulse: abort to IDLE.
REQ-009 wr_valid  in  1  wr_states holds a valid sample group this cycle.
REQ-010 wr_states  in  [CHANNELS][LANES]  sample bits, [channel][lane].
REQ-011 stg_mask / stg_match  in  [STAGES][CHANNELS]  per-stage pattern care mask and value.
REQ-012 stg_channel  in  [STAGES][$clog2(CHANNELS)]  per-stage edge/level channel.
REQ-013 stg_mode  in  [STAGES][3]  per-stage mode code.
REQ-014 stg_count  in  [STAGES][CNT_W]  occurrences required to pass a stage.
REQ-015 num_stages  in  $clog2(STAGES+1)  active stage count.
REQ-016 trig_valid  out  1  one-cycle pulse on final-stage hit.
REQ-017 trig_pos  out  $clog2(LANES)  lane of the final hit.
REQ-018 armed / done  out  1 each  state == ARMED / state == FIRED.
REQ-019 stage  out  $clog2(STAGES)  current stage index.

Function
REQ-020 Pattern hit per lane: for every channel c with stg_mask[c]=1, sample bit equals stg_match[c]; unmasked channels are ignored.
REQ-021 Mode per lane, with b = lane bit of stg_channel and p = the previous lane's bit: 0 always; 1 rising (!p&&b); 2 falling; 3 either edge; 4 high; 5 low; 6-7 never.
REQ-022 For lane 0, p comes from the last lane of the previous wr_valid cycle, held in a CHANNELS-bit register; if no valid cycle has occurred since arm, lane-0 edge modes never hit.
REQ-023 Stage condition per lane = pattern hit AND mode hit; the event lane is the lowest lane satisfying it.
REQ-024 States: IDLE, ARMED, FIRED. arm in IDLE or FIRED -> ARMED with stage=0, counter=0, history invalidated.
REQ-025 In ARMED, on a wr_valid cycle with an event: if counter+1 >= max(stg_count,1), the stage passes; otherwise counter increments.
REQ-026 Passing the stage at index eff-1 -> FIRED, where eff = num_stages clamped to [1,STAGES]; passing any earlier stage -> stage+1, counter=0.
REQ-027 At most one event is counted per clock cycle; a new stage is evaluated from the next cycle.
REQ-028 trig_valid=1 and trig_pos=event lane are registered, asserted the cycle after the firing sample cycle, for exactly one cycle.
REQ-029 Cycles with wr_valid=0 change no state, counter, or history.
REQ-030 disarm -> IDLE from any state and wins over a simultaneous arm or event.
REQ-031 arm while ARMED restarts at stage 0; an event in the same cycle is discarded.
REQ-032 cfg inputs are read live and change only while in IDLE or FIRED.

Reset
REQ-033 rst -> state IDLE; stage, counter, history, trig_valid, trig_pos, armed, done all 0.
REQ-034 rst asserted mid-sequence discards all progress, and no trig_valid is produced.

Structure
REQ-035 Package trigger_pkg holds the trig_mode_e enum (codes above) and the trig_state_e enum.
REQ-036 Sub-module trigger_lane_match: one stage's combinational lane evaluation, outputting hit flag and lowest lane; one instance muxed by the current stage.

Verification
REQ-037 mode=1 on ch3, mask=0, count=1, 1 stage; ch3 lanes 0-2 low, 3-7 high -> trig_valid next cycle, trig_pos=3.
REQ-038 2 stages: stage0 pattern ch0=1 count=3, stage1 falling ch5; three ch0-high cycles, then ch5 falls at lane 6 -> stage=1 after the third cycle, trig_pos=6.
REQ-039 ch2 high at lane 7 of cycle N, low at lane 0 of cycle N+1 with mode=2 -> trig_pos=0; the same sequence with an idle cycle in between still hits.
REQ-040 First valid cycle after arm has ch1=1 at lane 0 with mode=1 -> no hit at lane 0.
REQ-041 disarm and arm together during stage 1 -> IDLE, armed=0, no trig_valid.
REQ-042 num_stages=0 and num_stages>STAGES -> behave as 1 and STAGES stages respectively.

Source files
------------

// File: rtl/trigger_pkg.sv
// Trigger sequencer shared types.
// Mode codes and sequencer state encoding.
package trigger_pkg;

  typedef enum logic [2:0] {
    M_ALWAYS = 3'd0,
    M_RISE   = 3'd1,
    M_FALL   = 3'd2,
    M_EDGE   = 3'd3,
    M_HIGH   = 3'd4,
    M_LOW    = 3'd5,
    M_NEVER6 = 3'd6,
    M_NEVER7 = 3'd7
  } trig_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRED = 2'd2
  } trig_state_e;

endpackage

// File: rtl/trigger_lane_match.sv
// One stage's per-lane pattern and mode evaluation.
// Reports whether any lane hits and the lowest hitting lane.
module trigger_lane_match
  import trigger_pkg::*;
#(
  parameter int LANES    = 8,
  parameter int CHANNELS = 32,
  parameter int CH_W     = $clog2(CHANNELS),
  parameter int POS_W    = $clog2(LANES)
) (
  input  logic [CHANNELS-1:0][LANES-1:0] states,
  input  logic [CHANNELS-1:0]            prev,
  input  logic                           prev_vld,
  input  logic [CHANNELS-1:0]            mask,
  input  logic [CHANNELS-1:0]            match,
  input  logic [CH_W-1:0]                channel,
  input  logic [2:0]                     mode,
  output logic                           hit,
  output logic [POS_W-1:0]               pos
);

  logic [LANES-1:0] pat;
  logic [LANES-1:0] bsel;
  logic [LANES-1:0] psel;
  logic [LANES-1:0] pval;
  logic [LANES-1:0] mh;
  logic [LANES-1:0] cond;

  // Pattern compare on every lane; masked-off channels never block a hit.
  always_comb begin
    pat = '1;
    for (int l = 0; l < LANES; l++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (mask[c] && (states[c][l] != match[c])) pat[l] = 1'b0;
      end
    end
  end

  // Mode compare; lane 0 edges lean on the carried-over last lane.
  always_comb begin
    bsel = states[channel];
    psel = {bsel[LANES-2:0], prev[channel]};
    pval = {{(LANES-1){1'b1}}, prev_vld};
    mh   = '0;
    unique case (trig_mode_e'(mode))
      M_ALWAYS: mh = '1;
      M_RISE:   mh = pval & ~psel & bsel;
      M_FALL:   mh = pval & psel & ~bsel;
      M_EDGE:   mh = pval & (psel ^ bsel);
      M_HIGH:   mh = bsel;
      M_LOW:    mh = ~bsel;
      default:  mh = '0;
    endcase
  end

  // Lowest satisfying lane wins.
  always_comb begin
    cond = pat & mh;
    hit  = |cond;
    pos  = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (cond[l]) pos = POS_W'(l);
    end
  end

endmodule

// File: rtl/trigger_seq.sv
// Multi-stage logic-analyzer trigger sequencer.
// Counts per-stage occurrences and fires once the last stage passes.
module trigger_seq
  import trigger_pkg::*;
#(
  parameter int LANES    = 8,
  parameter int CHANNELS = 32,
  parameter int STAGES   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 arm,
  input  logic                                 disarm,
  input  logic                                 wr_valid,
  input  logic [CHANNELS-1:0][LANES-1:0]       wr_states,
  input  logic [STAGES-1:0][CHANNELS-1:0]      stg_mask,
  input  logic [STAGES-1:0][CHANNELS-1:0]      stg_match,
  input  logic [STAGES-1:0][$clog2(CHANNELS)-1:0] stg_channel,
  input  logic [STAGES-1:0][2:0]               stg_mode,
  input  logic [STAGES-1:0][CNT_W-1:0]         stg_count,
  input  logic [$clog2(STAGES+1)-1:0]          num_stages,
  output logic                                 trig_valid,
  output logic [$clog2(LANES)-1:0]             trig_pos,
  output logic                                 armed,
  output logic                                 done,
  output logic [$clog2(STAGES)-1:0]            stage
);

  localparam int POS_W = $clog2(LANES);
  localparam int STG_W = $clog2(STAGES);
  localparam int NS_W  = $clog2(STAGES + 1);

  trig_state_e        state_q, state_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CHANNELS-1:0] prev_q, prev_d;
  logic               hvld_q, hvld_d;
  logic               tv_q, tv_d;
  logic [POS_W-1:0]   tp_q, tp_d;

  logic               ev_hit;
  logic [POS_W-1:0]   ev_pos;
  logic [STG_W-1:0]   last_stg;
  logic [CNT_W:0]     need;
  logic [CNT_W:0]     cnt_inc;

  trigger_lane_match #(
    .LANES    (LANES),
    .CHANNELS (CHANNELS)
  ) u_match (
    .states   (wr_states),
    .prev     (prev_q),
    .prev_vld (hvld_q),
    .mask     (stg_mask[stage_q]),
    .match    (stg_match[stage_q]),
    .channel  (stg_channel[stage_q]),
    .mode     (stg_mode[stage_q]),
    .hit      (ev_hit),
    .pos      (ev_pos)
  );

  // Last active stage index and pass threshold; zero counts mean one.
  always_comb begin
    if (num_stages == '0)
      last_stg = '0;
    else if (num_stages > NS_W'(STAGES))
      last_stg = STG_W'(STAGES - 1);
    else
      last_stg = STG_W'(num_stages - 1'b1);
    if (stg_count[stage_q] == '0)
      need = (CNT_W+1)'(1);
    else
      need = {1'b0, stg_count[stage_q]};
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  end

  // Sequencer next state: disarm beats arm beats sample processing.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    hvld_d  = hvld_q;
    tv_d    = 1'b0;
    tp_d    = tp_q;
    if (disarm) begin
      state_d = S_IDLE;
    end else if (arm) begin
      state_d = S_ARMED;
      stage_d = '0;
      cnt_d   = '0;
      hvld_d  = 1'b0;
    end else if (wr_valid) begin
      for (int c = 0; c < CHANNELS; c++)
        prev_d[c] = wr_states[c][LANES-1];
      hvld_d = 1'b1;
      if (state_q == S_ARMED && ev_hit) begin
        if (cnt_inc >= need) begin
          cnt_d = '0;
          if (stage_q >= last_stg) begin
            state_d = S_FIRED;
            tv_d    = 1'b1;
            tp_d    = ev_pos;
          end else begin
            stage_d = stage_q + STG_W'(1);
          end
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
    end
  end

  // State, progress, history and trigger output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      prev_q  <= '0;
      hvld_q  <= 1'b0;
      tv_q    <= 1'b0;
      tp_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      hvld_q  <= hvld_d;
      tv_q    <= tv_d;
      tp_q    <= tp_d;
    end
  end

  assign trig_valid = tv_q;
  assign trig_pos   = tp_q;
  assign armed      = (state_q == S_ARMED);
  assign done       = (state_q == S_FIRED);
  assign stage      = stage_q;

endmodule

// File: tb/tb_trigger_seq.sv
// Self-checking bench for trigger_seq.
// Directed vectors plus randomized traffic against a reference model.
module tb_trigger_seq;

  localparam int L = 8;
  localparam int C = 32;
  localparam int S = 4;
  localparam int W = 16;

  typedef logic [C-1:0][L-1:0] smp_t;

  logic clk = 1'b0;
  logic rst, arm, disarm, wr_valid;
  smp_t wr_states;
  logic [S-1:0][C-1:0] stg_mask, stg_match;
  logic [S-1:0][4:0] stg_channel;
  logic [S-1:0][2:0] stg_mode;
  logic [S-1:0][W-1:0] stg_count;
  logic [2:0] num_stages;
  logic trig_valid, armed, done;
  logic [2:0] trig_pos;
  logic [1:0] stage;

  trigger_seq #(.LANES(L), .CHANNELS(C), .STAGES(S), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .disarm(disarm),
    .wr_valid(wr_valid), .wr_states(wr_states),
    .stg_mask(stg_mask), .stg_match(stg_match),
    .stg_channel(stg_channel), .stg_mode(stg_mode),
    .stg_count(stg_count), .num_stages(num_stages),
    .trig_valid(trig_valid), .trig_pos(trig_pos),
    .armed(armed), .done(done), .stage(stage)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // reference model: 0 idle, 1 armed, 2 fired
  int m_st, m_stage, m_cnt, m_tp;
  bit m_tv, m_hv;
  bit [C-1:0] m_prev;

  function automatic int ev_lane();
    for (int l = 0; l < L; l++) begin
      bit ok, b, p, pv, mh;
      int ch;
      ok = 1;
      for (int c = 0; c < C; c++)
        if (stg_mask[m_stage][c] && wr_states[c][l] != stg_match[m_stage][c])
          ok = 0;
      ch = int'(stg_channel[m_stage]);
      b = wr_states[ch][l];
      if (l == 0) begin
        p = m_prev[ch];
        pv = m_hv;
      end else begin
        p = wr_states[ch][l-1];
        pv = 1;
      end
      case (int'(stg_mode[m_stage]))
        0: mh = 1;
        1: mh = pv && !p && b;
        2: mh = pv && p && !b;
        3: mh = pv && (p != b);
        4: mh = b;
        5: mh = !b;
        default: mh = 0;
      endcase
      if (ok && mh) return l;
    end
    return -1;
  endfunction

  task automatic model_step();
    int e, need, eff;
    m_tv = 0;
    if (rst) begin
      m_st = 0; m_stage = 0; m_cnt = 0;
      m_prev = '0; m_hv = 0; m_tp = 0;
    end else if (disarm) begin
      m_st = 0;
    end else if (arm) begin
      m_st = 1; m_stage = 0; m_cnt = 0; m_hv = 0;
    end else if (wr_valid) begin
      e = ev_lane();
      if (m_st == 1 && e >= 0) begin
        need = (stg_count[m_stage] == 0) ? 1 : int'(stg_count[m_stage]);
        eff = (num_stages == 0) ? 1 :
              (num_stages > S) ? S : int'(num_stages);
        if (m_cnt + 1 >= need) begin
          m_cnt = 0;
          if (m_stage == eff - 1) begin
            m_st = 2; m_tv = 1; m_tp = e;
          end else begin
            m_stage++;
          end
        end else begin
          m_cnt++;
        end
      end
      for (int c = 0; c < C; c++) m_prev[c] = wr_states[c][L-1];
      m_hv = 1;
    end
  endtask

  task automatic cmp(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp("m_tv", int'(trig_valid), int'(m_tv));
    cmp("m_pos", int'(trig_pos), m_tp);
    cmp("m_stage", int'(stage), m_stage);
    cmp("m_armed", int'(armed), int'(m_st == 1));
    cmp("m_done", int'(done), int'(m_st == 2));
  endtask

  task automatic cyc(bit a, bit d, bit v, smp_t s);
    arm = a; disarm = d; wr_valid = v; wr_states = s;
    tick();
    arm = 0; disarm = 0; wr_valid = 0;
  endtask

  task automatic exp5(string n, bit tv, int tp, int stg, bit ar, bit dn);
    cmp({n, ".tv"}, int'(trig_valid), int'(tv));
    cmp({n, ".pos"}, int'(trig_pos), tp);
    cmp({n, ".stage"}, int'(stage), stg);
    cmp({n, ".armed"}, int'(armed), int'(ar));
    cmp({n, ".done"}, int'(done), int'(dn));
  endtask

  task automatic clr_cfg();
    stg_mask = '0; stg_match = '0; stg_channel = '0;
    stg_mode = '0; stg_count = '0; num_stages = 3'd1;
  endtask

  typedef struct {
    bit a, d, v;
    smp_t s;
    bit tv;
    int tp, stg;
    bit ar, dn;
  } vec_t;

  vec_t tbl[6];
  smp_t z, s;

  initial begin
    z = '0;
    // rising edge on ch3 table
    s = '0; s[3] = 8'hF8;
    tbl[0] = '{1, 0, 0, z, 0, 0, 0, 1, 0};
    tbl[1] = '{0, 0, 1, s, 1, 3, 0, 0, 1};
    tbl[2] = '{0, 0, 0, z, 0, 3, 0, 0, 1};
    tbl[3] = '{1, 0, 0, z, 0, 3, 0, 1, 0};
    s = '0; s[3] = 8'h01;
    tbl[4] = '{0, 0, 1, s, 0, 3, 0, 1, 0};
    s = '0; s[3] = 8'hFE;
    tbl[5] = '{0, 0, 1, s, 1, 1, 0, 0, 1};

    rst = 1; arm = 0; disarm = 0; wr_valid = 0; wr_states = '0;
    clr_cfg();
    tick();
    tick();
    exp5("reset", 0, 0, 0, 0, 0);
    rst = 0;

    stg_mode[0] = 3'd1; stg_channel[0] = 5'd3; stg_count[0] = 16'd1;
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].a, tbl[i].d, tbl[i].v, tbl[i].s);
      exp5($sformatf("tbl%0d", i), tbl[i].tv, tbl[i].tp, tbl[i].stg,
           tbl[i].ar, tbl[i].dn);
    end

    // two stages: count 3 on ch0 pattern, then falling ch5
    cyc(0, 1, 0, z);
    exp5("dis1", 0, 1, 0, 0, 0);
    clr_cfg();
    num_stages = 3'd2;
    stg_mask[0] = 32'h1; stg_match[0] = 32'h1; stg_count[0] = 16'd3;
    stg_mode[1] = 3'd2; stg_channel[1] = 5'd5; stg_count[1] = 16'd1;
    cyc(1, 0, 0, z);
    s = '0; s[0] = 8'hFF;
    cyc(0, 0, 1, s);
    cyc(0, 0, 1, s);
    exp5("cnt2", 0, 1, 0, 1, 0);
    cyc(0, 0, 1, s);
    exp5("cnt3", 0, 1, 1, 1, 0);
    s = '0; s[5] = 8'h3F;
    cyc(0, 0, 1, s);
    exp5("fall6", 1, 6, 1, 0, 1);

    // falling edge across the cycle boundary, with and without a gap
    cyc(0, 1, 0, z);
    exp5("dis2", 0, 6, 1, 0, 0);
    clr_cfg();
    stg_mode[0] = 3'd2; stg_channel[0] = 5'd2; stg_count[0] = 16'd1;
    cyc(1, 0, 0, z);
    s = '0; s[2] = 8'h80;
    cyc(0, 0, 1, s);
    exp5("l7hi", 0, 6, 0, 1, 0);
    cyc(0, 0, 1, z);
    exp5("xfall", 1, 0, 0, 0, 1);
    cyc(1, 0, 0, z);
    cyc(0, 0, 1, s);
    cyc(0, 0, 0, z);
    exp5("gap", 0, 0, 0, 1, 0);
    cyc(0, 0, 1, z);
    exp5("xfall_gap", 1, 0, 0, 0, 1);

    // no lane-0 edge before any history
    cyc(0, 1, 0, z);
    clr_cfg();
    stg_mode[0] = 3'd1; stg_channel[0] = 5'd1; stg_count[0] = 16'd1;
    cyc(1, 0, 0, z);
    s = '0; s[1] = 8'h01;
    cyc(0, 0, 1, s);
    exp5("nohist", 0, 0, 0, 1, 0);
    s = '0; s[1] = 8'h06;
    cyc(0, 0, 1, s);
    exp5("rise1", 1, 1, 0, 0, 1);

    // disarm wins over arm and event; arm restart drops event
    cyc(0, 1, 0, z);
    clr_cfg();
    num_stages = 3'd2;
    stg_count[0] = 16'd1; stg_count[1] = 16'd1;
    cyc(1, 0, 0, z);
    cyc(0, 0, 1, z);
    exp5("st1", 0, 1, 1, 1, 0);
    cyc(1, 1, 1, z);
    exp5("disarm_arm", 0, 1, 1, 0, 0);
    cyc(1, 0, 0, z);
    cyc(0, 0, 1, z);
    cyc(1, 0, 1, z);
    exp5("rearm", 0, 1, 0, 1, 0);
    cyc(0, 0, 1, z);
    cyc(0, 0, 1, z);
    exp5("fire2", 1, 0, 1, 0, 1);

    // num_stages clamping; count 0 behaves as 1
    num_stages = 3'd0;
    stg_count[0] = 16'd0; stg_mode[1] = 3'd6;
    cyc(1, 0, 0, z);
    cyc(0, 0, 1, z);
    exp5("ns0", 1, 0, 0, 0, 1);
    clr_cfg();
    num_stages = 3'd7;
    for (int i = 0; i < S; i++) stg_count[i] = 16'd1;
    cyc(1, 0, 0, z);
    cyc(0, 0, 1, z);
    cyc(0, 0, 1, z);
    cyc(0, 0, 1, z);
    exp5("ns7_st3", 0, 0, 3, 1, 0);
    cyc(0, 0, 1, z);
    exp5("ns7_fire", 1, 0, 3, 0, 1);

    // reset mid-sequence
    cyc(1, 0, 0, z);
    cyc(0, 0, 1, z);
    rst = 1;
    cyc(0, 0, 1, z);
    exp5("rst_mid", 0, 0, 0, 0, 0);
    rst = 0;

    // randomized episodes against the model
    for (int ep = 0; ep < 30; ep++) begin
      cyc(0, 1, 0, z);
      for (int i = 0; i < S; i++) begin
        stg_mask[i] = ($urandom_range(0, 2) == 0) ? 32'h0 :
                      (32'h1 << $urandom_range(0, 31));
        stg_match[i] = $urandom;
        stg_channel[i] = 5'($urandom_range(0, 31));
        stg_mode[i] = 3'($urandom_range(0, 7));
        stg_count[i] = 16'($urandom_range(0, 3));
      end
      num_stages = 3'($urandom_range(0, 7));
      for (int k = 0; k < 40; k++) begin
        smp_t r;
        for (int c = 0; c < C; c++) r[c] = 8'($urandom);
        cyc((k == 0) || ($urandom_range(0, 29) == 0),
            $urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0, r);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
